// File: rtl/bmp_pkg.sv
// Shared constants and encodings for the BMP master-port receiver.
package bmp_pkg;

  localparam int unsigned BMP_HEADER_BYTES = 56;

  localparam logic [7:0] BMP_SIG0 = 8'h42;  // 'B'
  localparam logic [7:0] BMP_SIG1 = 8'h4D;  // 'M'

  // file_size occupies header bytes 2..5, little-endian
  localparam int unsigned BMP_FSIZE_OFF_LO = 2;
  localparam int unsigned BMP_FSIZE_OFF_HI = 5;

  localparam int unsigned ERR_SIG = 0;
  localparam int unsigned ERR_LEN = 1;
  localparam int unsigned ERR_SRC = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_BODY  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bmp_state_e;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with registered full/empty flags and a synchronous flush.
module sync_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // Flags are registered, so a pop never frees a slot for a push in the same cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;
  assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/bmp_master_rx.sv
// Receives scheduler words, serialises them to bytes and parses the BMP header,
// closing each frame on the byte count or on the scheduler's completion strobe.
module bmp_master_rx
  import bmp_pkg::*;
#(
  parameter int unsigned DATA_BUS_SIZE = 32,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned HEADER_BYTES  = BMP_HEADER_BYTES,
  parameter int unsigned MAX_FILE_SIZE = 1000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_BUS_SIZE-1:0] data_to_master,
  input  logic [1:0]               mstr0_data_valid,
  input  logic                     mstr0_cmplt,
  output logic                     mstr0_ready,
  output logic [7:0]               out_byte,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     out_src,
  output logic [31:0]              file_size,
  output logic                     frame_done,
  output logic [2:0]               err,
  output logic                     busy
);

  localparam int unsigned BYTES_PER_DATA = DATA_BUS_SIZE >> 3;
  localparam int unsigned IDX_W = (BYTES_PER_DATA > 1) ? $clog2(BYTES_PER_DATA) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_DATA - 1);
  localparam logic [31:0] HDR_END  = 32'(HEADER_BYTES);
  localparam logic [31:0] MAX_SIZE = 32'(MAX_FILE_SIZE);

  bmp_state_e state_q, state_d;

  logic [DATA_BUS_SIZE-1:0] fifo_rdata, sh_q;
  logic                     fifo_full, fifo_empty;
  logic [IDX_W-1:0]         idx_q;
  logic                     ser_valid_q;
  logic [31:0]              cnt_q, fsize_q, fsize_new, eff_end;
  logic [2:0]               err_q;
  logic                     src_q;
  logic [1:0]               lane;
  logic [7:0]               cur_byte;
  logic                     in_frame, accept, fire, is_last, last_fire, word_end, pop;
  logic                     in_size_field;

  // Handshakes: a word moves when mstr0_data_valid[0] && mstr0_ready at a rising
  // edge; a byte moves when out_valid && out_ready. out_byte/out_valid only
  // change after a byte moves, so they hold steady while the sink stalls.
  assign in_frame  = (state_q == ST_HDR) || (state_q == ST_BODY) || (state_q == ST_DRAIN);
  assign accept    = mstr0_data_valid[0] && mstr0_ready;
  assign fire      = ser_valid_q && out_ready;
  assign cur_byte  = sh_q[DATA_BUS_SIZE-1 -: 8];
  assign eff_end   = (fsize_q < HDR_END || fsize_q > MAX_SIZE) ? HDR_END : fsize_q;
  assign is_last   = ser_valid_q && (cnt_q + 32'd1 == eff_end);
  assign last_fire = fire && is_last;
  assign word_end  = fire && (idx_q == LAST_IDX);
  // Padding after the final byte is dropped by refusing to load another word.
  assign pop       = in_frame && !fifo_empty && (!ser_valid_q || (word_end && !is_last));

  assign in_size_field = (cnt_q >= 32'(BMP_FSIZE_OFF_LO)) && (cnt_q <= 32'(BMP_FSIZE_OFF_HI));
  assign lane          = cnt_q[1:0] - 2'd2;

  always_comb begin
    fsize_new = fsize_q;
    fsize_new[{lane, 3'b000} +: 8] = cur_byte;
  end

  sync_word_fifo #(
    .WIDTH (DATA_BUS_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (state_q == ST_DONE),
    .push_i  (accept),
    .wdata_i (data_to_master),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_HDR;
      ST_HDR: begin
        if (last_fire)                                state_d = ST_DONE;
        else if (mstr0_cmplt)                         state_d = ST_DRAIN;
        else if (fire && cnt_q == HDR_END - 32'd1)    state_d = ST_BODY;
      end
      ST_BODY: begin
        if (last_fire)        state_d = ST_DONE;
        else if (mstr0_cmplt) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (last_fire || (fifo_empty && !ser_valid_q)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mstr0_ready = rst_n && !fifo_full && (state_q != ST_DRAIN) && (state_q != ST_DONE);
    frame_done  = (state_q == ST_DONE);
    busy        = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q        <= '0;
      idx_q       <= '0;
      ser_valid_q <= 1'b0;
      cnt_q       <= '0;
      fsize_q     <= '0;
      err_q       <= '0;
      src_q       <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && accept) begin
        cnt_q   <= '0;
        fsize_q <= '0;
        err_q   <= '0;
        src_q   <= mstr0_data_valid[1];
      end else begin
        if (accept && (mstr0_data_valid[1] != src_q)) err_q[ERR_SRC] <= 1'b1;
        if (fire) begin
          cnt_q <= cnt_q + 32'd1;
          if (cnt_q == 32'd0 && cur_byte != BMP_SIG0) err_q[ERR_SIG] <= 1'b1;
          if (cnt_q == 32'd1 && cur_byte != BMP_SIG1) err_q[ERR_SIG] <= 1'b1;
          if (in_size_field) begin
            fsize_q <= fsize_new;
            if (cnt_q == 32'(BMP_FSIZE_OFF_HI) && (fsize_new < HDR_END || fsize_new > MAX_SIZE))
              err_q[ERR_LEN] <= 1'b1;
          end
        end
        // Drained dry before reaching the expected end: frame was short.
        if (state_q == ST_DRAIN && !last_fire && fifo_empty && !ser_valid_q && cnt_q < eff_end)
          err_q[ERR_LEN] <= 1'b1;
      end

      if (state_q == ST_DONE) begin
        ser_valid_q <= 1'b0;
      end else if (pop) begin
        sh_q        <= fifo_rdata;
        idx_q       <= '0;
        ser_valid_q <= 1'b1;
      end else if (fire) begin
        sh_q  <= sh_q << 8;
        idx_q <= idx_q + IDX_W'(1);
        if (word_end || is_last) ser_valid_q <= 1'b0;
      end
    end
  end

  assign out_byte  = cur_byte;
  assign out_valid = ser_valid_q;
  assign out_last  = is_last;
  assign out_src   = src_q;
  assign file_size = fsize_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bmp_master_rx.sv
// Directed bench for bmp_master_rx: builds BMP frames, drives words, collects bytes.
module tb_bmp_master_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_to_master = '0;
  logic [1:0]  mstr0_data_valid = '0;
  logic        mstr0_cmplt = 1'b0;
  logic        out_ready = 1'b1;
  logic        mstr0_ready, out_valid, out_last, out_src, frame_done, busy;
  logic [7:0]  out_byte;
  logic [31:0] file_size;
  logic [2:0]  err;

  always #5 clk = ~clk;

  bmp_master_rx dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_to_master   (data_to_master),
    .mstr0_data_valid (mstr0_data_valid),
    .mstr0_cmplt      (mstr0_cmplt),
    .mstr0_ready      (mstr0_ready),
    .out_byte         (out_byte),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .out_src          (out_src),
    .file_size        (file_size),
    .frame_done       (frame_done),
    .err              (err),
    .busy             (busy)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int   last_cnt, last_idx, done_cnt, acc_cnt, max_out, stall_viol, stall_seen;
  bit   saw_ready_low;
  logic [7:0] frame_b [0:127];
  bit   frame_src [0:31];
  logic prev_v, prev_r;
  logic [7:0] prev_b;

  // Monitor: samples on the falling edge, i.e. what the next rising edge will see.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_v && !prev_r) begin
        stall_seen++;
        if (out_valid !== 1'b1 || out_byte !== prev_b) stall_viol++;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_byte);
        if (out_last) begin
          last_cnt++;
          last_idx = got_q.size() - 1;
        end
      end
      if (frame_done) done_cnt++;
      if (mstr0_data_valid[0] && mstr0_ready) acc_cnt++;
      if (!mstr0_ready && busy) saw_ready_low = 1'b1;
      if (acc_cnt - got_q.size() / 4 > max_out) max_out = acc_cnt - got_q.size() / 4;
    end
    prev_v = out_valid;
    prev_r = out_ready;
    prev_b = out_byte;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    last_cnt = 0; last_idx = -1; done_cnt = 0; acc_cnt = 0; max_out = 0;
    stall_viol = 0; stall_seen = 0; saw_ready_low = 1'b0;
  endtask

  task automatic build_frame(input logic [7:0] sig1, input logic [31:0] size,
                             input bit src0, input int flip_at, input int n_exp);
    for (int i = 0; i < 128; i++) frame_b[i] = 8'((i * 7 + 3) & 255);
    frame_b[0] = 8'h42;
    frame_b[1] = sig1;
    frame_b[2] = size[7:0];
    frame_b[3] = size[15:8];
    frame_b[4] = size[23:16];
    frame_b[5] = size[31:24];
    for (int k = 0; k < 32; k++) frame_src[k] = (flip_at >= 0 && k >= flip_at) ? ~src0 : src0;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(frame_b[i]);
  endtask

  task automatic send_words(input int n);
    int tmo;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      data_to_master   = {frame_b[4*k], frame_b[4*k+1], frame_b[4*k+2], frame_b[4*k+3]};
      mstr0_data_valid = {frame_src[k], 1'b1};
      tmo = 0;
      while (!mstr0_ready && tmo < 300) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 300) break;
    end
    @(negedge clk);
    mstr0_data_valid = '0;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && done_cnt == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({out_byte, out_valid, out_last, out_src, file_size, frame_done, err, busy, mstr0_ready} !== '0)
      $display("FAIL reset_outputs: got byte=%h v=%b last=%b src=%b size=%h done=%b err=%b busy=%b rdy=%b, expected all 0",
               out_byte, out_valid, out_last, out_src, file_size, frame_done, err, busy, mstr0_ready);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({mstr0_ready, busy} !== 2'b10) $display("FAIL reset_idle: ready/busy=%b expected 10", {mstr0_ready, busy});
    else pass_cnt++;
  endtask

  task automatic test_legal();
    int bad;
    clear_sb();
    build_frame(8'h4D, 32'd64, 1'b0, -1, 64);
    send_words(16);
    wait_done(500);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
    total_cnt++;
    if (bad >= 0 || got_q.size() != 64) $display("FAIL legal_stream: %0d bytes, first bad index %0d, expected 64 matching bytes", got_q.size(), bad);
    else pass_cnt++;
    total_cnt++;
    if (last_cnt !== 1 || last_idx !== 63) $display("FAIL legal_last: count=%0d idx=%0d expected 1 at 63", last_cnt, last_idx);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL legal_done: pulses=%0d expected 1", done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (err !== 3'b000) $display("FAIL legal_err: got %b expected 000", err);
    else pass_cnt++;
    total_cnt++;
    if (file_size !== 32'd64) $display("FAIL legal_size: got %0d expected 64", file_size);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || acc_cnt !== 16) $display("FAIL legal_idle: busy=%b accepted=%0d expected 0 and 16", busy, acc_cnt);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int bad;
    clear_sb();
    build_frame(8'h4D, 32'd64, 1'b0, -1, 64);
    fork
      send_words(16);
      begin
        for (int c = 0; c < 800 && done_cnt == 0; c++) begin
          @(posedge clk);
          #1 out_ready = ~out_ready;
        end
        out_ready = 1'b1;
      end
    join
    wait_done(200);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
    total_cnt++;
    if (bad >= 0 || got_q.size() != 64) $display("FAIL stall_stream: %0d bytes, first bad index %0d, expected 64 matching bytes", got_q.size(), bad);
    else pass_cnt++;
    total_cnt++;
    if (stall_viol !== 0 || stall_seen == 0) $display("FAIL stall_hold: violations=%0d stalls=%0d expected 0 and >0", stall_viol, stall_seen);
    else pass_cnt++;
    total_cnt++;
    if (!saw_ready_low || max_out > 5) $display("FAIL stall_backpressure: ready_low=%b max_outstanding=%0d expected 1 and <=5", saw_ready_low, max_out);
    else pass_cnt++;
    total_cnt++;
    if (last_idx !== 63 || done_cnt !== 1 || err !== 3'b000) $display("FAIL stall_end: last=%0d done=%0d err=%b expected 63 1 000", last_idx, done_cnt, err);
    else pass_cnt++;
  endtask

  task automatic test_short();
    int bad;
    clear_sb();
    build_frame(8'h4D, 32'd62, 1'b0, -1, 62);
    send_words(17);
    wait_done(500);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
    total_cnt++;
    if (bad >= 0 || got_q.size() != 62) $display("FAIL short_stream: %0d bytes, first bad index %0d, expected 62 matching bytes", got_q.size(), bad);
    else pass_cnt++;
    total_cnt++;
    if (last_cnt !== 1 || last_idx !== 61) $display("FAIL short_last: count=%0d idx=%0d expected 1 at 61", last_cnt, last_idx);
    else pass_cnt++;
    total_cnt++;
    if (acc_cnt !== 17 || done_cnt !== 1 || busy !== 1'b0) $display("FAIL short_discard: accepted=%0d done=%0d busy=%b expected 17 1 0", acc_cnt, done_cnt, busy);
    else pass_cnt++;
    total_cnt++;
    if (err !== 3'b000 || file_size !== 32'd62) $display("FAIL short_status: err=%b size=%0d expected 000 62", err, file_size);
    else pass_cnt++;
  endtask

  task automatic test_cmplt();
    int bad;
    clear_sb();
    build_frame(8'h4D, 32'd64, 1'b0, -1, 60);
    send_words(15);
    mstr0_cmplt = 1'b1;
    @(negedge clk);
    mstr0_cmplt = 1'b0;
    wait_done(500);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
    total_cnt++;
    if (bad >= 0 || got_q.size() != 60) $display("FAIL cmplt_stream: %0d bytes, first bad index %0d, expected 60 matching bytes", got_q.size(), bad);
    else pass_cnt++;
    total_cnt++;
    if (last_cnt !== 0 || done_cnt !== 1) $display("FAIL cmplt_end: last=%0d done=%0d expected 0 1", last_cnt, done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (err !== 3'b010) $display("FAIL cmplt_err: got %b expected 010", err);
    else pass_cnt++;
  endtask

  task automatic test_badsig();
    int bad;
    clear_sb();
    build_frame(8'h58, 32'd32, 1'b0, -1, 56);
    send_words(16);
    wait_done(500);
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
    total_cnt++;
    if (bad >= 0 || got_q.size() != 56) $display("FAIL badsig_stream: %0d bytes, first bad index %0d, expected 56 matching bytes", got_q.size(), bad);
    else pass_cnt++;
    total_cnt++;
    if (last_cnt !== 1 || last_idx !== 55 || done_cnt !== 1) $display("FAIL badsig_last: count=%0d idx=%0d done=%0d expected 1 55 1", last_cnt, last_idx, done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (err !== 3'b011 || file_size !== 32'd32) $display("FAIL badsig_status: err=%b size=%0d expected 011 32", err, file_size);
    else pass_cnt++;
  endtask

  task automatic test_src_reset();
    int d0;
    clear_sb();
    build_frame(8'h4D, 32'd64, 1'b1, 3, 0);
    send_words(8);
    repeat (3) @(negedge clk);
    total_cnt++;
    if (out_src !== 1'b1 || err[2] !== 1'b1 || busy !== 1'b1) $display("FAIL src_mismatch: src=%b err=%b busy=%b expected 1 1xx 1", out_src, err, busy);
    else pass_cnt++;
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_byte, out_valid, out_last, out_src, file_size, frame_done, err, busy, mstr0_ready} !== '0)
      $display("FAIL midframe_reset: byte=%h v=%b src=%b size=%h err=%b busy=%b rdy=%b expected all 0",
               out_byte, out_valid, out_src, file_size, err, busy, mstr0_ready);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (done_cnt !== d0 || busy !== 1'b0) $display("FAIL reset_no_done: done=%0d busy=%b expected %0d 0", done_cnt, busy, d0);
    else pass_cnt++;
    test_legal();
  endtask

  initial begin
    test_reset();
    test_legal();
    test_stall();
    test_short();
    test_cmplt();
    test_badsig();
    test_src_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
